// File: rtl/output_sram_write_ctrl.sv
// Write-side front end for the banked output SRAM: a small request FIFO feeding
// single-cycle registered writes, held off while the read path owns the SRAM.
module output_sram_write_ctrl #(
    parameter int NUM_BANK   = 32,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data [0:NUM_BANK-1],
    input  logic [NUM_BANK-1:0] wr_mask,
    input  logic                sram_busy,
    output logic [ADDR_W-1:0]   output_SRAM_AB [0:NUM_BANK-1],
    output logic [DATA_W-1:0]   output_SRAM_DI [0:NUM_BANK-1],
    output logic [NUM_BANK-1:0] output_SRAM_WEN,
    output logic                output_SRAM_CEN,
    output logic [CNT_W-1:0]    write_count,
    input  logic                count_clr,
    output logic                idle
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0]   q_addr [0:FIFO_DEPTH-1];
    logic [DATA_W-1:0]   q_data [0:FIFO_DEPTH-1][0:NUM_BANK-1];
    logic [NUM_BANK-1:0] q_mask [0:FIFO_DEPTH-1];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             push;
    logic             pop;
    logic             head_live;

    // No bypass: a full FIFO refuses a push even when the head pops this cycle.
    assign wr_ready  = !rst && (occ < FULL_OCC);
    assign push      = wr_valid && wr_ready;
    assign pop       = (occ != '0) && !sram_busy;
    assign head_live = pop && (q_mask[rd_ptr] != '0);
    assign idle      = (occ == '0) && output_SRAM_CEN;

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= wr_addr;
            q_mask[wr_ptr] <= wr_mask;
            for (int b = 0; b < NUM_BANK; b++) begin
                q_data[wr_ptr][b] <= wr_data[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // An all-zero mask entry is popped but never reaches the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            output_SRAM_CEN <= 1'b1;
            output_SRAM_WEN <= '1;
            for (int b = 0; b < NUM_BANK; b++) begin
                output_SRAM_AB[b] <= '0;
                output_SRAM_DI[b] <= '0;
            end
        end else if (head_live) begin
            output_SRAM_CEN <= 1'b0;
            output_SRAM_WEN <= ~q_mask[rd_ptr];
            for (int b = 0; b < NUM_BANK; b++) begin
                output_SRAM_AB[b] <= q_addr[rd_ptr];
                output_SRAM_DI[b] <= q_data[rd_ptr][b];
            end
        end else begin
            output_SRAM_CEN <= 1'b1;
            output_SRAM_WEN <= '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || count_clr) begin
            write_count <= '0;
        end else if (head_live && (write_count != '1)) begin
            write_count <= write_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_output_sram_write_ctrl.sv
// Directed bench for output_sram_write_ctrl: a vector table for single-cycle
// behaviour plus hand sequences for backpressure, busy interleave and resets.
module tb_output_sram_write_ctrl;

    localparam int NB = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [31:0] wr_data [0:NB-1];
    logic [31:0] wr_mask;
    logic        sram_busy;
    logic [11:0] ab [0:NB-1];
    logic [31:0] di [0:NB-1];
    logic [31:0] wen;
    logic        cen;
    logic [15:0] write_count;
    logic        count_clr;
    logic        idle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    output_sram_write_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_mask         (wr_mask),
        .sram_busy       (sram_busy),
        .output_SRAM_AB  (ab),
        .output_SRAM_DI  (di),
        .output_SRAM_WEN (wen),
        .output_SRAM_CEN (cen),
        .write_count     (write_count),
        .count_clr       (count_clr),
        .idle            (idle)
    );

    typedef struct {
        logic        valid;
        logic [11:0] addr;
        logic [31:0] mask;
        logic [7:0]  seed;
        logic        busy;
        logic        clr;
        logic        e_ready;
        logic        e_cen;
        logic [31:0] e_wen;
        logic [11:0] e_ab;
        logic [31:0] e_di7;
        logic [15:0] e_cnt;
        logic        e_idle;
    } vec_t;

    vec_t vecs [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] a, input logic [31:0] m,
                         input logic [7:0] seed, input logic busy, input logic clr);
        wr_valid  = v;
        wr_addr   = a;
        wr_mask   = m;
        sram_busy = busy;
        count_clr = clr;
        for (int i = 0; i < NB; i++) begin
            wr_data[i] = (32'(seed) << 8) | 32'(i);
        end
    endtask

    logic [11:0] exp_q [$];
    logic        accepted;
    logic        prev_busy;
    int          sent;
    int          seen;

    initial begin
        // ready cen wen ab di7 cnt idle are the values expected after the edge
        vecs[0]  = '{1'b1, 12'h05A, 32'hFFFFFFFF, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 12'h000, 32'h000, 16'd0, 1'b0};
        vecs[1]  = '{1'b0, 12'h000, 32'h00000000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 12'h05A, 32'h007, 16'd1, 1'b0};
        vecs[2]  = '{1'b0, 12'h000, 32'h00000000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 12'h05A, 32'h007, 16'd1, 1'b1};
        vecs[3]  = '{1'b1, 12'h123, 32'h0000000F, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 12'h05A, 32'h007, 16'd1, 1'b0};
        vecs[4]  = '{1'b1, 12'h200, 32'h00000000, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFF0, 12'h123, 32'h107, 16'd2, 1'b0};
        vecs[5]  = '{1'b0, 12'h000, 32'h00000000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 12'h123, 32'h107, 16'd2, 1'b1};
        vecs[6]  = '{1'b0, 12'h000, 32'h00000000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 12'h123, 32'h107, 16'd2, 1'b1};
        vecs[7]  = '{1'b1, 12'h300, 32'hFFFFFFFF, 8'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 12'h123, 32'h107, 16'd2, 1'b0};
        vecs[8]  = '{1'b0, 12'h000, 32'h00000000, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 12'h123, 32'h107, 16'd2, 1'b0};
        vecs[9]  = '{1'b0, 12'h000, 32'h00000000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, 12'h300, 32'h307, 16'd3, 1'b0};
        vecs[10] = '{1'b0, 12'h000, 32'h00000000, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 12'h300, 32'h307, 16'd0, 1'b1};

        // reset held two cycles with a pending request
        rst = 1'b1;
        drive(1'b1, 12'h0AA, 32'hFFFFFFFF, 8'd9, 1'b0, 1'b0);
        #1;
        chk("rst_ready_comb", 32'(wr_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_ready", 32'(wr_ready), 32'd0);
            chk("rst_cen", 32'(cen), 32'd1);
            chk("rst_wen", wen, 32'hFFFFFFFF);
            chk("rst_cnt", 32'(write_count), 32'd0);
            chk("rst_idle", 32'(idle), 32'd1);
        end
        chk("rst_ab", 32'(ab[0]), 32'd0);
        chk("rst_di", di[7], 32'd0);
        rst = 1'b0;
        drive(1'b0, 12'h000, 32'h0, 8'd0, 1'b0, 1'b0);
        #1;
        chk("rel_ready", 32'(wr_ready), 32'd1);

        // single write, partial mask, zero mask, busy hold, clear
        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].valid, vecs[v].addr, vecs[v].mask, vecs[v].seed, vecs[v].busy, vecs[v].clr);
            step();
            chk($sformatf("v%0d_ready", v), 32'(wr_ready), 32'(vecs[v].e_ready));
            chk($sformatf("v%0d_cen", v), 32'(cen), 32'(vecs[v].e_cen));
            chk($sformatf("v%0d_wen", v), wen, vecs[v].e_wen);
            chk($sformatf("v%0d_ab0", v), 32'(ab[0]), 32'(vecs[v].e_ab));
            chk($sformatf("v%0d_ab31", v), 32'(ab[NB-1]), 32'(vecs[v].e_ab));
            chk($sformatf("v%0d_di7", v), di[7], vecs[v].e_di7);
            chk($sformatf("v%0d_cnt", v), 32'(write_count), 32'(vecs[v].e_cnt));
            chk($sformatf("v%0d_idle", v), 32'(idle), 32'(vecs[v].e_idle));
        end

        // backpressure: 4 fit while busy, the 5th waits for a pop
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 12'h600 + 12'(k), 32'hFFFFFFFF, 8'(k), 1'b1, 1'b0);
            #1;
            chk($sformatf("bp_ready%0d", k), 32'(wr_ready), (k < 4) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("bp_cen%0d", k), 32'(cen), 32'd1);
        end
        sram_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 1) wr_valid = 1'b0;
            chk($sformatf("bp_issue_cen%0d", k), 32'(cen), 32'd0);
            chk($sformatf("bp_issue_wen%0d", k), wen, 32'd0);
            chk($sformatf("bp_issue_ab%0d", k), 32'(ab[3]), 32'(12'h600 + 12'(k)));
            chk($sformatf("bp_issue_di%0d", k), di[7], (32'(k) << 8) | 32'd7);
        end
        step();
        chk("bp_after_cen", 32'(cen), 32'd1);
        chk("bp_after_idle", 32'(idle), 32'd1);
        chk("bp_cnt", 32'(write_count), 32'd5);

        // busy interleave stream of 8
        drive(1'b0, 12'h000, 32'h0, 8'd0, 1'b0, 1'b1);
        step();
        chk("il_clr", 32'(write_count), 32'd0);
        sent = 0;
        seen = 0;
        for (int cyc = 0; cyc < 60 && seen < 8; cyc++) begin
            drive(sent < 8, 12'h400 + 12'(sent), 32'hFFFFFFFF, 8'd4, (cyc % 2) == 1, 1'b0);
            #1;
            accepted  = wr_valid && wr_ready;
            prev_busy = sram_busy;
            if (accepted) begin
                exp_q.push_back(wr_addr);
                sent++;
            end
            step();
            if (cen == 1'b0) begin
                chk("il_busy_gate", 32'(prev_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("il_dup", 32'd1, 32'd0);
                end else begin
                    chk("il_order", 32'(ab[0]), 32'(exp_q.pop_front()));
                end
                seen++;
            end
        end
        chk("il_seen", 32'(seen), 32'd8);
        drive(1'b0, 12'h000, 32'h0, 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("il_quiet_cen", 32'(cen), 32'd1);
        end
        chk("il_cnt", 32'(write_count), 32'd8);

        // count_clr on an issuing edge
        drive(1'b1, 12'h777, 32'hFFFFFFFF, 8'd7, 1'b0, 1'b0);
        step();
        drive(1'b0, 12'h000, 32'h0, 8'd0, 1'b0, 1'b1);
        step();
        chk("clr_issue_cen", 32'(cen), 32'd0);
        chk("clr_issue_ab", 32'(ab[0]), 32'h777);
        chk("clr_issue_cnt", 32'(write_count), 32'd0);
        count_clr = 1'b0;
        step();
        chk("clr_after_cnt", 32'(write_count), 32'd0);

        // reset mid-burst with 3 entries still queued
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 12'h500 + 12'(k), 32'hFFFFFFFF, 8'd5, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 12'h000, 32'h0, 8'd0, 1'b0, 1'b0);
        step();
        chk("mb_cen", 32'(cen), 32'd0);
        chk("mb_ab", 32'(ab[0]), 32'h500);
        chk("mb_cnt", 32'(write_count), 32'd1);
        rst = 1'b1;
        step();
        chk("mb_rst_cen", 32'(cen), 32'd1);
        chk("mb_rst_wen", wen, 32'hFFFFFFFF);
        chk("mb_rst_ab", 32'(ab[0]), 32'd0);
        chk("mb_rst_di", di[7], 32'd0);
        chk("mb_rst_cnt", 32'(write_count), 32'd0);
        chk("mb_rst_idle", 32'(idle), 32'd1);
        chk("mb_rst_ready", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("mb_post_cen%0d", k), 32'(cen), 32'd1);
            chk($sformatf("mb_post_idle%0d", k), 32'(idle), 32'd1);
        end
        chk("mb_post_ready", 32'(wr_ready), 32'd1);
        chk("mb_post_cnt", 32'(write_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
